sobel_seq_ctrl: RTL
===================

SOBEL_SEQ_CTRL -- requirements
Module: sobel_seq_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, pixel width.
REQ-002 Parameters: ADDR_WIDTH, default 16, BRAM address width.
REQ-003 Parameters: IMAGE_WIDTH, default 100, pixels per row.
REQ-004 Parameters: IMAGE_HEIGHT, default 100, rows per frame.
REQ-005 Port list, one clock; reset is asynchronous and active-low:
  - clk  in  1  sole clock, rising edge
  - rst_n  in  1  async active-low reset
  - i_en  in  1  enable; low aborts any pass
  - i_run  in  1  start request, rising-edge sensitive
  - i_num_cnt  in  ADDR_WIDTH  pixels per pass
  - o_idle, o_read, o_write, o_done  out  1  status: idle / read phase / write phase / pass done pulse
  - o_abort  out  1  one-cycle pulse on abort
  - o_mode  out  1  0=MOVE pass, 1=SOBEL pass
  - rd_ce, rd_addr  out  1/ADDR_WIDTH  BRAM0 read port control
  - o_pix_vld, o_row, o_col  out  1/ADDR_WIDTH/ADDR_WIDTH  pixel strobe to datapath, aligned with BRAM0 q
  - i_dp_vld, i_dp_data  in  1/DATA_WIDTH  datapath result strobe and data
  - h_ce, h_we, h_addr, h_d  in  1/1/ADDR_WIDTH/DATA_WIDTH  host BRAM1 request
  - o_host_gnt  out  1  host owns BRAM1 port
  - b1_ce0, b1_we0, b1_addr0, b1_d0  out  1/1/ADDR_WIDTH/DATA_WIDTH  muxed BRAM1 port

Function
REQ-006 FSM states SHALL be IDLE, READ, DRAIN, DONE; o_idle=1 only in IDLE.
REQ-007 IDLE->READ SHALL occur when i_en=1 and i_run rises (registered 0->1 edge); i_num_cnt latched; o_mode=0 (MOVE).
REQ-008 READ SHALL assert rd_ce every cycle with rd_addr 0,1,...,N-1 starting the cycle after the start edge; o_read=1.
REQ-009 o_pix_vld SHALL equal rd_ce delayed one cycle (BRAM latency 1); o_row/o_col track that pixel, o_col wrapping at IMAGE_WIDTH-1 with o_row incrementing.
REQ-010 After address N-1 is issued, READ->DRAIN; o_write=1 while any result is outstanding (READ or DRAIN with write count < N).
REQ-011 Each i_dp_vld SHALL produce a registered BRAM1 write next cycle: b1_ce0=b1_we0=1, b1_addr0=write count, b1_d0=i_dp_data; write count increments.
REQ-012 When write count reaches N the FSM SHALL enter DONE, pulse o_done for exactly one cycle, then: if o_mode=0, set o_mode=1 and re-enter READ at address 0 next cycle; if o_mode=1, return to IDLE.
REQ-013 i_num_cnt=0: each pass SHALL complete with no read/write, two o_done pulses two cycles apart, then IDLE.
REQ-014 i_en low in any non-IDLE state SHALL force IDLE next cycle, pulse o_abort, no o_done, counters cleared, rd_ce and writes deasserted immediately.
REQ-015 i_dp_vld in IDLE SHALL be ignored; i_dp_vld beyond N in a pass SHALL be dropped.
REQ-016 o_host_gnt=1 only in IDLE; then b1_* SHALL be combinationally h_*; otherwise host requests ignored and b1_* driven by engine (zeros when no write).
REQ-017 i_run held high across passes SHALL NOT restart; a new start requires i_run low then high while IDLE.
REQ-018 Address and count arithmetic SHALL be ADDR_WIDTH unsigned, no wrap beyond N-1.

Reset
REQ-019 On rst_n low: state IDLE, o_idle=1, all other outputs 0, counters 0, o_mode=0, run-edge register 0.
REQ-020 Reset asserted mid-pass SHALL abandon the pass without o_done or o_abort.

Structure
REQ-021 State encoding and mode constants SHALL live in a shared package sobel_pkg used by the top and datapath.
REQ-022 One sub-module, sobel_b1_arb (BRAM1 port mux/grant), is natural; FSM and counters stay in sobel_seq_ctrl.

Verification
REQ-023 Start N=10000, datapath echoes q with 1-cycle latency -> rd_addr 0..9999 on consecutive cycles, 10000 writes per pass, two o_done pulses, o_mode 0 then 1, then IDLE.
REQ-024 o_pix_vld at read index 100 -> o_row=1, o_col=0; index 9999 -> o_row=99, o_col=99.
REQ-025 N=0 -> no rd_ce/b1_we0, o_done pulses two cycles apart, IDLE after.
REQ-026 i_en dropped at read index 50 -> o_abort pulse, IDLE next cycle, no further rd_ce or writes, no o_done.
REQ-027 Host write/read of BRAM1 addr 5 in IDLE -> passes through with o_host_gnt=1; same host request during READ -> ignored, o_host_gnt=0.
REQ-028 rst_n pulsed during DRAIN -> all outputs reset values, o_idle=1; i_run held high afterwards -> no start until toggled.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel sequencing engine: FSM state encoding and pass modes.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_MOVE  = 1'b0;
    localparam logic MODE_SOBEL = 1'b1;

endpackage

// File: rtl/sobel_b1_arb.sv
// BRAM1 port arbiter: the host owns the port while the engine is idle, the engine otherwise.
module sobel_b1_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_gnt,
    input  logic                  i_h_ce,
    input  logic                  i_h_we,
    input  logic [ADDR_WIDTH-1:0] i_h_addr,
    input  logic [DATA_WIDTH-1:0] i_h_d,
    input  logic                  i_e_ce,
    input  logic                  i_e_we,
    input  logic [ADDR_WIDTH-1:0] i_e_addr,
    input  logic [DATA_WIDTH-1:0] i_e_d,
    output logic                  o_host_gnt,
    output logic                  o_ce,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_d
);

    assign o_host_gnt = i_gnt;
    assign o_ce       = i_gnt ? i_h_ce   : i_e_ce;
    assign o_we       = i_gnt ? i_h_we   : i_e_we;
    assign o_addr     = i_gnt ? i_h_addr : i_e_addr;
    assign o_d        = i_gnt ? i_h_d    : i_e_d;

endmodule

// File: rtl/sobel_seq_ctrl.sv
// Sequencer for a two-pass (MOVE then SOBEL) frame: streams BRAM0 reads to the datapath
// and writes datapath results into BRAM1, sharing the BRAM1 port with a host while idle.
module sobel_seq_ctrl
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_num_cnt,
    output logic                  o_idle,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_done,
    output logic                  o_abort,
    output logic                  o_mode,
    output logic                  rd_ce,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  o_pix_vld,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic [ADDR_WIDTH-1:0] o_col,
    input  logic                  i_dp_vld,
    input  logic [DATA_WIDTH-1:0] i_dp_data,
    input  logic                  h_ce,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_d,
    output logic                  o_host_gnt,
    output logic                  b1_ce0,
    output logic                  b1_we0,
    output logic [ADDR_WIDTH-1:0] b1_addr0,
    output logic [DATA_WIDTH-1:0] b1_d0
);

    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(IMAGE_HEIGHT - 1);

    state_t                  r_state;
    logic                    r_run_d;
    logic                    r_armed;
    logic                    r_mode;
    logic                    r_done;
    logic                    r_abort;
    logic [ADDR_WIDTH-1:0]   r_num;
    logic                    r_rd_ce;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_irow;
    logic [ADDR_WIDTH-1:0]   r_icol;
    logic                    r_pix_vld;
    logic [ADDR_WIDTH-1:0]   r_row;
    logic [ADDR_WIDTH-1:0]   r_col;
    logic [ADDR_WIDTH-1:0]   r_wcnt;
    logic                    r_wr_vld;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_d;

    logic                    w_start;
    logic                    w_active;
    logic                    w_wr_acc;
    logic                    w_rd_ce;
    logic                    w_last;
    logic                    w_e_vld;

    // r_armed blocks a start straight out of reset while i_run is still held high.
    assign w_start  = (r_state == IDLE) && i_en && i_run && !r_run_d && r_armed;
    assign w_active = (r_state == READ) || (r_state == DRAIN);
    assign w_wr_acc = w_active && i_en && i_dp_vld && (r_wcnt < r_num);
    assign w_rd_ce  = r_rd_ce && i_en;
    assign w_last   = (r_rd_addr == r_num - ONE);
    assign w_e_vld  = r_wr_vld && i_en;

    assign o_idle    = (r_state == IDLE);
    assign o_read    = (r_state == READ);
    assign o_write   = w_active && (r_wcnt < r_num);
    assign o_done    = r_done;
    assign o_abort   = r_abort;
    assign o_mode    = r_mode;
    assign rd_ce     = w_rd_ce;
    assign rd_addr   = r_rd_addr;
    assign o_pix_vld = r_pix_vld;
    assign o_row     = r_row;
    assign o_col     = r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_run_d   <= 1'b0;
            r_armed   <= 1'b0;
            r_mode    <= MODE_MOVE;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_num     <= '0;
            r_rd_ce   <= 1'b0;
            r_rd_addr <= '0;
            r_irow    <= '0;
            r_icol    <= '0;
            r_pix_vld <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_wcnt    <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_d    <= '0;
        end else begin
            r_run_d <= i_run;
            if (!i_run)
                r_armed <= 1'b1;
            r_done  <= 1'b0;
            r_abort <= 1'b0;

            // BRAM0 has one cycle of read latency, so the pixel strobe trails rd_ce by one.
            r_pix_vld <= w_rd_ce;
            r_row     <= w_rd_ce ? r_irow : '0;
            r_col     <= w_rd_ce ? r_icol : '0;

            r_wr_vld  <= w_wr_acc;
            r_wr_addr <= w_wr_acc ? r_wcnt : '0;
            r_wr_d    <= w_wr_acc ? i_dp_data : '0;
            if (w_wr_acc)
                r_wcnt <= r_wcnt + ONE;

            if (r_state != IDLE && !i_en) begin
                r_state   <= IDLE;
                r_abort   <= 1'b1;
                r_mode    <= MODE_MOVE;
                r_rd_ce   <= 1'b0;
                r_rd_addr <= '0;
                r_irow    <= '0;
                r_icol    <= '0;
                r_wcnt    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_state   <= READ;
                            r_num     <= i_num_cnt;
                            r_mode    <= MODE_MOVE;
                            r_rd_ce   <= (i_num_cnt != '0);
                            r_rd_addr <= '0;
                            r_irow    <= '0;
                            r_icol    <= '0;
                            r_wcnt    <= '0;
                        end
                    end
                    READ: begin
                        if (r_num == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (w_last) begin
                            r_state   <= DRAIN;
                            r_rd_ce   <= 1'b0;
                            r_rd_addr <= '0;
                            r_irow    <= '0;
                            r_icol    <= '0;
                        end else begin
                            r_rd_addr <= r_rd_addr + ONE;
                            if (r_icol == COL_LAST) begin
                                r_icol <= '0;
                                r_irow <= (r_irow == ROW_LAST) ? '0 : r_irow + ONE;
                            end else begin
                                r_icol <= r_icol + ONE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (r_wcnt == r_num) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_wcnt <= '0;
                        if (r_mode == MODE_MOVE) begin
                            r_mode    <= MODE_SOBEL;
                            r_state   <= READ;
                            r_rd_ce   <= (r_num != '0);
                            r_rd_addr <= '0;
                            r_irow    <= '0;
                            r_icol    <= '0;
                        end else begin
                            r_mode  <= MODE_MOVE;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sobel_b1_arb #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_b1_arb (
        .i_gnt      (r_state == IDLE),
        .i_h_ce     (h_ce),
        .i_h_we     (h_we),
        .i_h_addr   (h_addr),
        .i_h_d      (h_d),
        .i_e_ce     (w_e_vld),
        .i_e_we     (w_e_vld),
        .i_e_addr   (w_e_vld ? r_wr_addr : '0),
        .i_e_d      (w_e_vld ? r_wr_d : '0),
        .o_host_gnt (o_host_gnt),
        .o_ce       (b1_ce0),
        .o_we       (b1_we0),
        .o_addr     (b1_addr0),
        .o_d        (b1_d0)
    );

endmodule
